// File: rtl/text_overlay_engine.sv
// Multi-line text overlay: per-line position/length/zoom/blink, character buffer,
// score-to-decimal digit substitution for reserved character codes, 2-stage pixel pipeline to the font ROM.
module text_overlay_engine #(
   parameter int unsigned NUM_LINES    = 4,
   parameter int unsigned MAX_CHARS    = 16,
   parameter int unsigned SCORE_W      = 8,
   parameter int unsigned SCORE_DIGITS = 3,
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         frame_start,
   input  logic [9:0]                   DrawX,
   input  logic [9:0]                   DrawY,
   input  logic [SCORE_W-1:0]           score,
   input  logic                         score_load,
   output logic                         score_busy,
   input  logic                         cfg_we,
   input  logic [$clog2(NUM_LINES)-1:0] cfg_line,
   input  logic [9:0]                   cfg_x,
   input  logic [9:0]                   cfg_y,
   input  logic [$clog2(MAX_CHARS):0]   cfg_len,
   input  logic                         cfg_scale,
   input  logic                         cfg_blink,
   input  logic                         cfg_en,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_LINES)-1:0] wr_line,
   input  logic [$clog2(MAX_CHARS)-1:0] wr_col,
   input  logic [7:0]                   wr_char,
   output logic [10:0]                  font_addr,
   output logic [2:0]                   glyph_col,
   output logic                         text_hit,
   output logic [$clog2(NUM_LINES)-1:0] hit_line,
   output logic                         blink_phase
);

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 64'd1;
      for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam int unsigned LW      = $clog2(NUM_LINES);
   localparam int unsigned CW      = $clog2(MAX_CHARS);
   localparam int unsigned LENW    = CW + 1;
   localparam int unsigned BW      = 4 * SCORE_DIGITS;
   localparam int unsigned SCW     = $clog2(SCORE_W + 1);
   localparam int unsigned FCW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam longint unsigned SAT_LIM = pow10(SCORE_DIGITS);

   logic [9:0]           r_cfg_x   [NUM_LINES];
   logic [9:0]           r_cfg_y   [NUM_LINES];
   logic [LENW-1:0]      r_cfg_len [NUM_LINES];
   logic [NUM_LINES-1:0] r_cfg_scale;
   logic [NUM_LINES-1:0] r_cfg_blink;
   logic [NUM_LINES-1:0] r_cfg_en;

   logic [7:0]           r_buf [NUM_LINES][MAX_CHARS];

   logic                 r_s1_hit;
   logic [LW-1:0]        r_s1_line;
   logic [CW-1:0]        r_s1_col;
   logic [2:0]           r_s1_gcol;
   logic [3:0]           r_s1_row;

   logic [10:0]          r_font_addr;
   logic [2:0]           r_glyph_col;
   logic                 r_text_hit;
   logic [LW-1:0]        r_hit_line;

   logic                 r_busy;
   logic                 r_sat;
   logic [SCW-1:0]       r_cnt;
   logic [SCORE_W-1:0]   r_shift;
   logic [BW-1:0]        r_bcd;
   logic [BW-1:0]        r_digits;

   logic [FCW-1:0]       r_blink_cnt;
   logic                 r_blink_phase;

   // Line configuration registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(NUM_LINES); i++) begin
            r_cfg_x[i]   <= '0;
            r_cfg_y[i]   <= '0;
            r_cfg_len[i] <= '0;
         end
         r_cfg_scale <= '0;
         r_cfg_blink <= '0;
         r_cfg_en    <= '0;
      end else if (cfg_we) begin
         r_cfg_x[cfg_line]     <= cfg_x;
         r_cfg_y[cfg_line]     <= cfg_y;
         r_cfg_len[cfg_line]   <= cfg_len;
         r_cfg_scale[cfg_line] <= cfg_scale;
         r_cfg_blink[cfg_line] <= cfg_blink;
         r_cfg_en[cfg_line]    <= cfg_en;
      end
   end

   // Character RAM, no reset; read-before-write on address collision
   always_ff @(posedge Clk) begin
      if (wr_en) r_buf[wr_line][wr_col] <= wr_char;
   end

   logic [10:0]          w_px;
   logic [10:0]          w_py;
   logic [NUM_LINES-1:0] w_hit;
   logic [CW-1:0]        w_col  [NUM_LINES];
   logic [2:0]           w_gcol [NUM_LINES];
   logic [3:0]           w_row  [NUM_LINES];

   assign w_px = {1'b0, DrawX};
   assign w_py = {1'b0, DrawY};

   // Per-line window test in 11 bits so x+width never wraps
   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      logic [10:0] w_x0, w_y0, w_wid, w_hgt, w_dxr, w_dyr, w_dx, w_dy;
      assign w_x0  = {1'b0, r_cfg_x[g]};
      assign w_y0  = {1'b0, r_cfg_y[g]};
      assign w_wid = r_cfg_scale[g] ? 11'({r_cfg_len[g], 4'b0000}) : 11'({r_cfg_len[g], 3'b000});
      assign w_hgt = r_cfg_scale[g] ? 11'd32 : 11'd16;
      assign w_dxr = w_px - w_x0;
      assign w_dyr = w_py - w_y0;
      assign w_dx  = r_cfg_scale[g] ? (w_dxr >> 1) : w_dxr;
      assign w_dy  = r_cfg_scale[g] ? (w_dyr >> 1) : w_dyr;
      assign w_hit[g] = r_cfg_en[g] && (r_cfg_len[g] != '0)
                        && (!r_cfg_blink[g] || r_blink_phase)
                        && (w_px >= w_x0) && (w_px < w_x0 + w_wid)
                        && (w_py >= w_y0) && (w_py < w_y0 + w_hgt);
      assign w_col[g]  = CW'(w_dx >> 3);
      assign w_gcol[g] = 3'(w_dx);
      assign w_row[g]  = 4'(w_dy);
   end

   logic          w_s1_hit;
   logic [LW-1:0] w_s1_line;
   logic [CW-1:0] w_s1_col;
   logic [2:0]    w_s1_gcol;
   logic [3:0]    w_s1_row;

   // Lowest-index hitting line wins: scan downward so line 0 is applied last
   always_comb begin
      w_s1_hit  = 1'b0;
      w_s1_line = '0;
      w_s1_col  = '0;
      w_s1_gcol = '0;
      w_s1_row  = '0;
      for (int l = int'(NUM_LINES) - 1; l >= 0; l--) begin
         if (w_hit[l]) begin
            w_s1_hit  = 1'b1;
            w_s1_line = LW'(l);
            w_s1_col  = w_col[l];
            w_s1_gcol = w_gcol[l];
            w_s1_row  = w_row[l];
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_s1_hit  <= 1'b0;
         r_s1_line <= '0;
         r_s1_col  <= '0;
         r_s1_gcol <= '0;
         r_s1_row  <= '0;
      end else begin
         r_s1_hit  <= w_s1_hit;
         r_s1_line <= w_s1_line;
         r_s1_col  <= w_s1_col;
         r_s1_gcol <= w_s1_gcol;
         r_s1_row  <= w_s1_row;
      end
   end

   logic [7:0]    w_code;
   logic [3:0]    w_digit;
   logic [6:0]    w_font;
   logic          w_o_hit;
   logic [10:0]   w_o_addr;
   logic [2:0]    w_o_gcol;
   logic [LW-1:0] w_o_line;

   assign w_code = r_buf[r_s1_line][r_s1_col];

   // Codes 0x80.. select a score digit (index 0 = most significant); other high codes are blank
   always_comb begin
      w_digit  = '0;
      w_font   = '0;
      w_o_hit  = 1'b0;
      w_o_addr = '0;
      w_o_gcol = '0;
      w_o_line = '0;
      for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
         if (w_code[6:0] == 7'(i)) w_digit = r_digits[4*(int'(SCORE_DIGITS)-1-i) +: 4];
      end
      if (r_s1_hit) begin
         if (!w_code[7]) begin
            w_o_hit = 1'b1;
            w_font  = w_code[6:0];
         end else if (w_code[6:0] < 7'(SCORE_DIGITS)) begin
            w_o_hit = 1'b1;
            w_font  = 7'h30 + 7'(w_digit);
         end
      end
      if (w_o_hit) begin
         w_o_addr = {w_font, r_s1_row};
         w_o_gcol = r_s1_gcol;
         w_o_line = r_s1_line;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_font_addr <= '0;
         r_glyph_col <= '0;
         r_text_hit  <= 1'b0;
         r_hit_line  <= '0;
      end else begin
         r_font_addr <= w_o_addr;
         r_glyph_col <= w_o_gcol;
         r_text_hit  <= w_o_hit;
         r_hit_line  <= w_o_line;
      end
   end

   logic [BW-1:0] w_bcd_adj;
   logic [BW-1:0] w_bcd_next;

   // Double-dabble step: add 3 to digits >= 5, then shift in the next binary bit
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
      w_bcd_next = BW'({w_bcd_adj, r_shift[SCORE_W-1]});
   end

   // Displayed digits change only on the final iteration, never mid-conversion
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_busy   <= 1'b0;
         r_sat    <= 1'b0;
         r_cnt    <= '0;
         r_shift  <= '0;
         r_bcd    <= '0;
         r_digits <= '0;
      end else if (!r_busy) begin
         if (score_load) begin
            r_busy  <= 1'b1;
            r_sat   <= (64'(score) >= SAT_LIM);
            r_cnt   <= '0;
            r_shift <= score;
            r_bcd   <= '0;
         end
      end else begin
         r_bcd   <= w_bcd_next;
         r_shift <= r_shift << 1;
         r_cnt   <= r_cnt + SCW'(1);
         if (r_cnt == SCW'(SCORE_W - 1)) begin
            r_busy   <= 1'b0;
            r_digits <= r_sat ? {SCORE_DIGITS{4'd9}} : w_bcd_next;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (frame_start) begin
         if (r_blink_cnt == FCW'(BLINK_FRAMES - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt   <= r_blink_cnt + FCW'(1);
         end
      end
   end

   assign font_addr   = r_font_addr;
   assign glyph_col   = r_glyph_col;
   assign text_hit    = r_text_hit;
   assign hit_line    = r_hit_line;
   assign score_busy  = r_busy;
   assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_text_overlay_engine.sv
// Directed bench for text_overlay_engine: one instance with 3 score digits and
// 2-frame blink, a second with 2 score digits for saturation.
module tb_text_overlay_engine;

   logic        Clk = 1'b0;
   logic        Reset, frame_start, score_load, cfg_we, cfg_scale, cfg_blink, cfg_en, wr_en;
   logic [9:0]  DrawX, DrawY, cfg_x, cfg_y;
   logic [7:0]  score, wr_char;
   logic [1:0]  cfg_line, wr_line;
   logic [4:0]  cfg_len;
   logic [3:0]  wr_col;

   logic        score_busy, text_hit, blink_phase;
   logic [10:0] font_addr;
   logic [2:0]  glyph_col;
   logic [1:0]  hit_line;
   logic        score_busy2, text_hit2, blink_phase2;
   logic [10:0] font_addr2;
   logic [2:0]  glyph_col2;
   logic [1:0]  hit_line2;

   logic [16:0] obs, obs2;
   assign obs  = {text_hit, hit_line, font_addr, glyph_col};
   assign obs2 = {text_hit2, hit_line2, font_addr2, glyph_col2};

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   text_overlay_engine #(.SCORE_DIGITS(3), .BLINK_FRAMES(2)) u_dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
      .score(score), .score_load(score_load), .score_busy(score_busy),
      .cfg_we(cfg_we), .cfg_line(cfg_line), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_len(cfg_len),
      .cfg_scale(cfg_scale), .cfg_blink(cfg_blink), .cfg_en(cfg_en),
      .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col), .wr_char(wr_char),
      .font_addr(font_addr), .glyph_col(glyph_col), .text_hit(text_hit),
      .hit_line(hit_line), .blink_phase(blink_phase));

   text_overlay_engine #(.SCORE_DIGITS(2), .BLINK_FRAMES(2)) u_dut2 (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
      .score(score), .score_load(score_load), .score_busy(score_busy2),
      .cfg_we(cfg_we), .cfg_line(cfg_line), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_len(cfg_len),
      .cfg_scale(cfg_scale), .cfg_blink(cfg_blink), .cfg_en(cfg_en),
      .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col), .wr_char(wr_char),
      .font_addr(font_addr2), .glyph_col(glyph_col2), .text_hit(text_hit2),
      .hit_line(hit_line2), .blink_phase(blink_phase2));

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic set_cfg(input logic [1:0] l, input logic [9:0] x, input logic [9:0] y,
                          input logic [4:0] len, input logic sc, input logic bl, input logic en);
      cfg_we = 1'b1; cfg_line = l; cfg_x = x; cfg_y = y; cfg_len = len;
      cfg_scale = sc; cfg_blink = bl; cfg_en = en;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic put_char(input logic [1:0] l, input logic [3:0] c, input logic [7:0] ch);
      wr_en = 1'b1; wr_line = l; wr_col = c; wr_char = ch;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic probe(input logic [9:0] x, input logic [9:0] y);
      DrawX = x; DrawY = y;
      tick();
      tick();
   endtask

   task automatic pulse_frame;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      Reset = 1'b1; frame_start = 1'b0; score_load = 1'b0; cfg_we = 1'b0; wr_en = 1'b0;
      DrawX = '0; DrawY = '0; score = '0; cfg_line = '0; cfg_x = '0; cfg_y = '0; cfg_len = '0;
      cfg_scale = 1'b0; cfg_blink = 1'b0; cfg_en = 1'b0; wr_line = '0; wr_col = '0; wr_char = '0;
      tick(); tick(); tick();
      n_checks++;
      if (obs !== 17'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, 17'h0); end
      n_checks++;
      if (score_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", score_busy); end
      n_checks++;
      if (blink_phase !== 1'b1) begin n_fail++; $display("FAIL reset_blink got=%b exp=1", blink_phase); end
      Reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_line;
      set_cfg(2'd0, 10'd290, 10'd360, 5'd3, 1'b0, 1'b0, 1'b1);
      put_char(2'd0, 4'd0, 8'h53);
      put_char(2'd0, 4'd1, 8'h43);
      put_char(2'd0, 4'd2, 8'h4F);
      probe(10'd299, 10'd365);
      n_checks++;
      if (obs !== {1'b1, 2'd0, 11'h435, 3'd1}) begin n_fail++; $display("FAIL basic_hit got=%h exp=%h", obs, {1'b1, 2'd0, 11'h435, 3'd1}); end
      probe(10'd313, 10'd375);
      n_checks++;
      if (obs !== {1'b1, 2'd0, 11'h4FF, 3'd7}) begin n_fail++; $display("FAIL basic_last_px got=%h exp=%h", obs, {1'b1, 2'd0, 11'h4FF, 3'd7}); end
      probe(10'd314, 10'd365);
      n_checks++;
      if (obs !== 17'h0) begin n_fail++; $display("FAIL basic_right_edge got=%h exp=0", obs); end
      probe(10'd289, 10'd365);
      n_checks++;
      if (obs !== 17'h0) begin n_fail++; $display("FAIL basic_left_edge got=%h exp=0", obs); end
   endtask

   task automatic test_scaled_line;
      set_cfg(2'd1, 10'd310, 10'd380, 5'd1, 1'b1, 1'b0, 1'b1);
      put_char(2'd1, 4'd0, 8'h50);
      probe(10'd325, 10'd411);
      n_checks++;
      if (obs !== {1'b1, 2'd1, 11'h50F, 3'd7}) begin n_fail++; $display("FAIL scaled_hit got=%h exp=%h", obs, {1'b1, 2'd1, 11'h50F, 3'd7}); end
      probe(10'd325, 10'd412);
      n_checks++;
      if (obs !== 17'h0) begin n_fail++; $display("FAIL scaled_bottom got=%h exp=0", obs); end
   endtask

   task automatic test_score;
      set_cfg(2'd3, 10'd0, 10'd0, 5'd4, 1'b0, 1'b0, 1'b1);
      put_char(2'd3, 4'd0, 8'h80);
      put_char(2'd3, 4'd1, 8'h81);
      put_char(2'd3, 4'd2, 8'h82);
      put_char(2'd3, 4'd3, 8'h83);
      score = 8'd237; score_load = 1'b1;
      tick();
      score_load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (score_busy !== 1'b1) begin n_fail++; $display("FAIL busy_cycle%0d got=%b exp=1", i, score_busy); end
         if (i == 2) begin score = 8'd100; score_load = 1'b1; end
         tick();
         score_load = 1'b0;
      end
      n_checks++;
      if (score_busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall got=%b exp=0", score_busy); end
      probe(10'd0, 10'd0);
      n_checks++;
      if (obs !== {1'b1, 2'd3, 11'h320, 3'd0}) begin n_fail++; $display("FAIL score237_d0 got=%h exp=%h", obs, {1'b1, 2'd3, 11'h320, 3'd0}); end
      n_checks++;
      if (obs2 !== {1'b1, 2'd3, 11'h390, 3'd0}) begin n_fail++; $display("FAIL sat237_d0 got=%h exp=%h", obs2, {1'b1, 2'd3, 11'h390, 3'd0}); end
      probe(10'd8, 10'd0);
      n_checks++;
      if (obs !== {1'b1, 2'd3, 11'h330, 3'd0}) begin n_fail++; $display("FAIL score237_d1 got=%h exp=%h", obs, {1'b1, 2'd3, 11'h330, 3'd0}); end
      probe(10'd16, 10'd0);
      n_checks++;
      if (obs !== {1'b1, 2'd3, 11'h370, 3'd0}) begin n_fail++; $display("FAIL score237_d2 got=%h exp=%h", obs, {1'b1, 2'd3, 11'h370, 3'd0}); end
      n_checks++;
      if (obs2 !== 17'h0) begin n_fail++; $display("FAIL sat_placeholder_range got=%h exp=0", obs2); end
      probe(10'd24, 10'd0);
      n_checks++;
      if (obs !== 17'h0) begin n_fail++; $display("FAIL placeholder_range got=%h exp=0", obs); end
      score = 8'd255; score_load = 1'b1;
      tick();
      score_load = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      probe(10'd8, 10'd0);
      n_checks++;
      if (obs !== {1'b1, 2'd3, 11'h350, 3'd0}) begin n_fail++; $display("FAIL score255_d1 got=%h exp=%h", obs, {1'b1, 2'd3, 11'h350, 3'd0}); end
      n_checks++;
      if (obs2 !== {1'b1, 2'd3, 11'h390, 3'd0}) begin n_fail++; $display("FAIL sat255_d1 got=%h exp=%h", obs2, {1'b1, 2'd3, 11'h390, 3'd0}); end
      probe(10'd0, 10'd0);
      n_checks++;
      if (obs !== {1'b1, 2'd3, 11'h320, 3'd0}) begin n_fail++; $display("FAIL score255_d0 got=%h exp=%h", obs, {1'b1, 2'd3, 11'h320, 3'd0}); end
   endtask

   task automatic test_priority;
      set_cfg(2'd2, 10'd296, 10'd368, 5'd2, 1'b0, 1'b0, 1'b1);
      put_char(2'd2, 4'd0, 8'h41);
      put_char(2'd2, 4'd1, 8'h42);
      probe(10'd300, 10'd370);
      n_checks++;
      if (obs !== {1'b1, 2'd0, 11'h43A, 3'd2}) begin n_fail++; $display("FAIL priority_line0 got=%h exp=%h", obs, {1'b1, 2'd0, 11'h43A, 3'd2}); end
      set_cfg(2'd0, 10'd290, 10'd360, 5'd3, 1'b0, 1'b0, 1'b0);
      probe(10'd300, 10'd370);
      n_checks++;
      if (obs !== {1'b1, 2'd2, 11'h412, 3'd4}) begin n_fail++; $display("FAIL priority_line2 got=%h exp=%h", obs, {1'b1, 2'd2, 11'h412, 3'd4}); end
   endtask

   task automatic test_blink;
      set_cfg(2'd0, 10'd0, 10'd100, 5'd1, 1'b0, 1'b1, 1'b1);
      put_char(2'd0, 4'd0, 8'h48);
      set_cfg(2'd1, 10'd100, 10'd100, 5'd1, 1'b0, 1'b0, 1'b1);
      put_char(2'd1, 4'd0, 8'h49);
      probe(10'd3, 10'd101);
      n_checks++;
      if (obs !== {1'b1, 2'd0, 11'h481, 3'd3}) begin n_fail++; $display("FAIL blink_initial got=%h exp=%h", obs, {1'b1, 2'd0, 11'h481, 3'd3}); end
      pulse_frame();
      n_checks++;
      if (blink_phase !== 1'b1) begin n_fail++; $display("FAIL blink_one_pulse got=%b exp=1", blink_phase); end
      pulse_frame();
      n_checks++;
      if (blink_phase !== 1'b0) begin n_fail++; $display("FAIL blink_two_pulses got=%b exp=0", blink_phase); end
      probe(10'd3, 10'd101);
      n_checks++;
      if (obs !== 17'h0) begin n_fail++; $display("FAIL blink_hidden got=%h exp=0", obs); end
      probe(10'd103, 10'd101);
      n_checks++;
      if (obs !== {1'b1, 2'd1, 11'h491, 3'd3}) begin n_fail++; $display("FAIL nonblink_visible got=%h exp=%h", obs, {1'b1, 2'd1, 11'h491, 3'd3}); end
      pulse_frame();
      pulse_frame();
      probe(10'd3, 10'd101);
      n_checks++;
      if (obs !== {1'b1, 2'd0, 11'h481, 3'd3}) begin n_fail++; $display("FAIL blink_reshown got=%h exp=%h", obs, {1'b1, 2'd0, 11'h481, 3'd3}); end
   endtask

   task automatic test_reset_mid;
      probe(10'd0, 10'd0);
      n_checks++;
      if (obs !== {1'b1, 2'd3, 11'h320, 3'd0}) begin n_fail++; $display("FAIL pre_reset_hit got=%h exp=%h", obs, {1'b1, 2'd3, 11'h320, 3'd0}); end
      score = 8'd200; score_load = 1'b1;
      tick();
      score_load = 1'b0;
      tick();
      n_checks++;
      if (score_busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy got=%b exp=1", score_busy); end
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      n_checks++;
      if (score_busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got=%b exp=0", score_busy); end
      n_checks++;
      if (obs !== 17'h0) begin n_fail++; $display("FAIL reset_mid_outputs got=%h exp=0", obs); end
      tick();
      tick();
      @(negedge Clk);
      Reset = 1'b0;
      tick();
      probe(10'd0, 10'd0);
      n_checks++;
      if (obs !== 17'h0) begin n_fail++; $display("FAIL post_reset_hidden got=%h exp=0", obs); end
      set_cfg(2'd3, 10'd0, 10'd0, 5'd4, 1'b0, 1'b0, 1'b1);
      probe(10'd0, 10'd0);
      n_checks++;
      if (obs !== {1'b1, 2'd3, 11'h300, 3'd0}) begin n_fail++; $display("FAIL post_reset_digits got=%h exp=%h", obs, {1'b1, 2'd3, 11'h300, 3'd0}); end
      n_checks++;
      if (obs2 !== {1'b1, 2'd3, 11'h300, 3'd0}) begin n_fail++; $display("FAIL post_reset_digits2 got=%h exp=%h", obs2, {1'b1, 2'd3, 11'h300, 3'd0}); end
   endtask

   initial begin
      test_reset();
      test_basic_line();
      test_scaled_line();
      test_score();
      test_priority();
      test_blink();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
